// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
// Holds the controller state enum, the minimum legal ratio and the high-phase helper.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // Widened so that D = 2^CNT_W-1 cannot overflow.
    function automatic int unsigned half_hi(input int unsigned d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Ratio request handshake between the config block and the divider controller.
// The config side is the master; the controller is the slave.
interface clk_div_cfg_ctrl_if #(
    parameter int CNT_W = 8
);
    import clk_div_pkg::*;

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_wave.sv
// Divided-clock waveform generator: period counter plus posedge/negedge phase registers.
// Odd ratios AND the two phases to get a high time of D/2 source periods.
module clk_div_wave
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             wrap_o,
    output logic             clk_out_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pos_q;
    logic             pos_d;
    logic             neg_q;

    assign wrap_o = busy_i && (cnt_q == div_i - CNT_W'(1));

    always_comb begin
        cnt_d = '0;
        if (busy_i && !wrap_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pos_d = run_i && (32'(cnt_d) < half_hi(32'(div_i)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pos_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pos_q <= pos_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out_o = div_i[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Run-time divider controller: ratio handshake, glitch-free ratio switch and clean gating.
// Define CLK_DIV_PERIOD_CNT_EN to add the saturating period_cnt output.
module clk_div_cfg_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    clk_div_cfg_ctrl_if.slave    cfg,
    output logic                 clk_out,
    output logic [CNT_W-1:0]     div_active,
    output logic                 busy,
    output logic                 period_tick
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]          period_cnt
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             pend_vld_q;
    logic             pend_vld_d;
    logic             err_q;
    logic             err_d;
    logic             xfer;
    logic             legal;
    logic             tick;

    assign cfg.cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign cfg.cfg_err   = err_q;
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign legal         = xfer && (32'(cfg.cfg_div) >= MIN_DIV);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = xfer && !legal;
        unique case (state_q)
            IDLE: begin
                if (legal) div_d = cfg.cfg_div;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (legal) begin
                    pend_d     = cfg.cfg_div;
                    pend_vld_d = 1'b1;
                    state_d    = PEND;
                end
                if (!en) state_d = STOP;
            end
            PEND: begin
                if (tick) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = en ? RUN : STOP;
                end else if (!en) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // A ratio queued before en dropped still lands here.
                if (tick) begin
                    if (pend_vld_q) begin
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                    state_d = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= CNT_W'(DEF_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    clk_div_wave #(
        .CNT_W(CNT_W)
    ) u_wave (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy_i   (busy),
        .run_i    (state_d != IDLE),
        .div_i    (div_q),
        .wrap_o   (tick),
        .clk_out_o(clk_out)
    );

    assign busy        = (state_q != IDLE);
    assign div_active  = div_q;
    assign period_tick = tick;

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (div_d != div_q) begin
            pcnt_q <= '0;
        end else if (tick && (pcnt_q != 16'hFFFF)) begin
            pcnt_q <= pcnt_q + 16'd1;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule
